// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: single-issue sequencer in front of a multi-cycle FPU ALU.
// One command is in flight at a time. The operands and the op code are held on
// the ALU for a fixed per-op latency, then the ALU result is captured and
// offered as a response.
//
// Handshakes: a transfer happens on a rising FPUCLK edge where valid && ready
// are both high. cmd_ready is high only in IDLE. rsp_valid is high only in
// RESP, and rsp_data/rsp_op/rsp_err stay stable until the edge that completes
// the response handshake.
module fpu_issue_ctrl #(
    parameter int unsigned ADDSUB_LAT = 12,
    parameter int unsigned MUL_LAT    = 12,
    parameter int unsigned DIV_LAT    = 50
) (
    input  logic        FPUCLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [2:0]  cmd_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [2:0]  rsp_op,
    output logic        rsp_err,
    output logic [15:0] ops_done,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_NONE  = 3'b111;
    localparam logic [7:0] L_ADDSUB = 8'(ADDSUB_LAT);
    localparam logic [7:0] L_MUL    = 8'(MUL_LAT);
    localparam logic [7:0] L_DIV    = 8'(DIV_LAT);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_op;
    logic [31:0] r_rsp_data;
    logic [2:0]  r_rsp_op;
    logic        r_rsp_err;
    logic [15:0] r_ops_done;

    logic        w_accept;
    logic        w_op_ok;
    logic        w_last;
    logic        w_rsp_hs;
    logic [7:0]  w_lat;

    // Latency to load into the down-counter for the incoming op code.
    always_comb begin
        w_lat = 8'd0;
        case (cmd_op)
            3'b000, 3'b001: w_lat = L_ADDSUB;
            3'b010:         w_lat = L_MUL;
            3'b011:         w_lat = L_DIV;
            default:        w_lat = 8'd0;
        endcase
    end

    // State register; reset aborts any in-flight operation.
    always_ff @(posedge FPUCLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and all state-derived outputs.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_op_ok      = ~cmd_op[2];
        w_last       = 1'b0;
        w_rsp_hs     = 1'b0;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        alu_a        = 32'd0;
        alu_b        = 32'd0;
        alu_ctrl     = OP_NONE;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                w_accept  = cmd_valid;
                if (cmd_valid) begin
                    // Invalid op codes bypass the ALU entirely.
                    w_next_state = w_op_ok ? S_EXEC : S_RESP;
                end
            end
            S_EXEC: begin
                alu_a    = r_a;
                alu_b    = r_b;
                alu_ctrl = r_op;
                w_last   = (r_cnt == 8'd1);
                if (w_last) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                w_rsp_hs  = rsp_ready;
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Command capture, latency countdown, result capture and completion count.
    always_ff @(posedge FPUCLK) begin
        if (RST) begin
            r_cnt      <= 8'd0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_op       <= 3'b000;
            r_rsp_data <= 32'd0;
            r_rsp_op   <= 3'b000;
            r_rsp_err  <= 1'b0;
            r_ops_done <= 16'd0;
        end else begin
            if (w_accept) begin
                r_a   <= cmd_a;
                r_b   <= cmd_b;
                r_op  <= cmd_op;
                r_cnt <= w_lat;
                if (!w_op_ok) begin
                    r_rsp_data <= 32'd0;
                    r_rsp_op   <= cmd_op;
                    r_rsp_err  <= 1'b1;
                end
            end
            if (r_state == S_EXEC) begin
                r_cnt <= r_cnt - 8'd1;
                if (w_last) begin
                    r_rsp_data <= alu_out;
                    r_rsp_op   <= r_op;
                    r_rsp_err  <= 1'b0;
                end
            end
            if (w_rsp_hs) begin
                r_ops_done <= r_ops_done + 16'd1;
            end
        end
    end

    assign rsp_data    = r_rsp_data;
    assign rsp_op      = r_rsp_op;
    assign rsp_err     = r_rsp_err;
    assign ops_done    = r_ops_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed bench for fpu_issue_ctrl. A behavioural ALU stub
// only returns the true result once the op has been held for its full latency,
// so early or late result sampling shows up as a data error.
module tb_fpu_issue_ctrl;

    localparam int LAT_AS  = 12;
    localparam int LAT_MUL = 12;
    localparam int LAT_DIV = 50;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  op;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [2:0]  cmd_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_op;
    logic        rsp_err;
    logic [15:0] ops_done;
    logic [1:0]  dbg_state;

    rsp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          exp_ops = 0;
    int          hold = 0;

    fpu_issue_ctrl dut (
        .FPUCLK      (clk),
        .RST         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_out     (alu_out),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_op      (rsp_op),
        .rsp_err     (rsp_err),
        .ops_done    (ops_done),
        .o_dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stub: counts how many cycles alu_ctrl has been held on a real op.
    always @(posedge clk) begin
        if (alu_ctrl == 3'b111) hold <= 0;
        else                    hold <= hold + 1;
    end

    function automatic int stub_lat(input logic [2:0] c);
        if (c == 3'd3) return LAT_DIV;
        if (c == 3'd2) return LAT_MUL;
        return LAT_AS;
    endfunction

    function automatic logic [31:0] stub_result(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        if (c == 3'd0 && a == 32'h40400000 && b == 32'h40800000) return 32'h40E00000;
        if (c == 3'd1 && a == 32'h40400000 && b == 32'h40800000) return 32'hBF800000;
        if (c == 3'd2 && a == 32'h40400000 && b == 32'h40800000) return 32'h41400000;
        if (c == 3'd3 && a == 32'h40400000 && b == 32'h40800000) return 32'h3F400000;
        if (c == 3'd0 && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
        if (c == 3'd2 && a == 32'h40200000 && b == 32'h40000000) return 32'h40A00000;
        return 32'h7FC00000;
    endfunction

    always_comb begin
        alu_out = 32'hBAD00000 | 32'(hold);
        if (alu_ctrl != 3'b111 && hold == stub_lat(alu_ctrl) - 1)
            alu_out = stub_result(alu_ctrl, alu_a, alu_b);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: compares every response handshake against the expected queue.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp actual=%h required=none", rsp_data);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_op", 32'(rsp_op), 32'(e.op));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    // Driver: issues one command, checks timing/ALU drive, and completes the
    // response after 'stall' cycles of rsp_ready low. Called just after a posedge.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_data, input int exp_lat, input int stall);
        rsp_t   e;
        int     lat;
        int     hold_bad;
        int     stall_bad;
        int     guard;
        logic   inv;
        logic [31:0] d0;
        inv = op[2];
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        rsp_ready = (stall == 0);
        e.data = exp_data;
        e.op   = op;
        e.err  = inv;
        exp_q.push_back(e);
        @(posedge clk); #1;
        // Scramble the command bus: the block must ignore it outside IDLE.
        cmd_valid = 1'b0;
        cmd_a     = 32'h12345678;
        cmd_b     = 32'h9ABCDEF0;
        cmd_op    = 3'b010;
        lat = 0;
        hold_bad = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (rsp_valid || lat > 300) break;
            if (inv) begin
                if (alu_ctrl !== 3'b111) hold_bad++;
            end else if (alu_ctrl !== op || alu_a !== a || alu_b !== b) begin
                hold_bad++;
            end
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("alu_hold", 32'(hold_bad), 32'd0);
        check("resp_cycle", {29'd0, cmd_ready, alu_ctrl == 3'b111, alu_a == 32'd0}, 32'd3);
        if (stall > 0) begin
            stall_bad = 0;
            d0 = rsp_data;
            for (int s = 0; s < stall; s++) begin
                if (!(rsp_valid && !cmd_ready && alu_ctrl == 3'b111 && rsp_data == d0 && rsp_op == op))
                    stall_bad++;
                @(posedge clk); #1;
                if (s == stall - 1) rsp_ready = 1'b1;
                @(negedge clk);
            end
            check("stall_hold", 32'(stall_bad), 32'd0);
            check("stall_valid", 32'(rsp_valid), 32'd1);
        end
        @(posedge clk); #1;
        exp_ops++;
        check("post_hs_valid", 32'(rsp_valid), 32'd0);
        check("post_hs_ready", 32'(cmd_ready), 32'd1);
        check("ops_done", 32'(ops_done), 32'(exp_ops));
    endtask

    initial begin
        int ghost;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = 32'd0;
        cmd_b     = 32'd0;
        cmd_op    = 3'd0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_outputs", {cmd_ready, rsp_valid, alu_ctrl, rsp_op, rsp_err}, {23'd0, 9'b1_0_111_000_0});
        check("rst_data", rsp_data ^ alu_a ^ alu_b, 32'd0);
        check("rst_ops", 32'(ops_done), 32'd0);
        @(posedge clk); #1;

        send(3'b000, 32'h40400000, 32'h40800000, 32'h40E00000, LAT_AS + 1, 0);
        send(3'b001, 32'h40400000, 32'h40800000, 32'hBF800000, LAT_AS + 1, 0);
        send(3'b010, 32'h40400000, 32'h40800000, 32'h41400000, LAT_MUL + 1, 0);
        send(3'b011, 32'h40400000, 32'h40800000, 32'h3F400000, LAT_DIV + 1, 0);
        send(3'b000, 32'h3F800000, 32'h3F800000, 32'h40000000, LAT_AS + 1, 5);
        send(3'b101, 32'h40400000, 32'h40800000, 32'h00000000, 1, 0);
        send(3'b111, 32'h3F800000, 32'h3F800000, 32'h00000000, 1, 2);
        send(3'b010, 32'h40200000, 32'h40000000, 32'h40A00000, LAT_MUL + 1, 1);

        // Reset in the middle of a DIV: no response may follow.
        cmd_valid = 1'b1;
        cmd_a     = 32'h40400000;
        cmd_b     = 32'h40800000;
        cmd_op    = 3'b011;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("abort_midexec", 32'(alu_ctrl), 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ctrl", 32'(alu_ctrl), 32'd7);
        check("abort_valid", 32'(rsp_valid), 32'd0);
        check("abort_ops", 32'(ops_done), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        exp_ops = 0;
        ghost = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid || alu_ctrl != 3'b111) ghost++;
        end
        check("abort_no_rsp", 32'(ghost), 32'd0);
        @(posedge clk); #1;

        send(3'b000, 32'h40400000, 32'h40800000, 32'h40E00000, LAT_AS + 1, 0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
